// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch stage: FSM state encoding,
//   instruction field bit positions and widths, and the immediate
//   sign-extension helper used by the field splitter.
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } fetch_state_e;

    localparam int OPC_W = 5;
    localparam int REG_W = 5;
    localparam int IMM_W = 17;
    localparam int TGT_W = 27;
    localparam int SX_W  = 32;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 27;
    localparam int RD_MSB    = 26;
    localparam int RD_LSB    = 22;
    localparam int RS_MSB    = 21;
    localparam int RS_LSB    = 17;
    localparam int RT_MSB    = 16;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_MSB = 11;
    localparam int SHAMT_LSB = 7;
    localparam int FUNC_MSB  = 6;
    localparam int FUNC_LSB  = 2;
    localparam int IMM_MSB   = 16;
    localparam int IMM_LSB   = 0;
    localparam int TGT_MSB   = 26;
    localparam int TGT_LSB   = 0;

    // Sign-extend the 17-bit immediate to a full 32-bit operand.
    function automatic logic [SX_W-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
        return {{(SX_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_field_split.sv
// -----------------------------------------------------------------------------
// fetch_field_split
//   Purely combinational split of a 32-bit instruction word into the fields
//   consumed by the control decoder and register file.
//   Ports:
//     instr   in  INSN_W  instruction word
//     opcode  out 5       instr[31:27]
//     rd      out 5       instr[26:22]
//     rs      out 5       instr[21:17]
//     rt      out 5       instr[16:12]
//     shamt   out 5       instr[11:7]
//     alu_in  out 5       instr[6:2] (R-type func)
//     imm_sx  out 32      sign-extended instr[16:0]
//     target  out 27      instr[26:0]
// -----------------------------------------------------------------------------
module fetch_field_split
    import fetch_pkg::*;
#(
    parameter int INSN_W = 32
) (
    input  logic [INSN_W-1:0] instr,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rs,
    output logic [REG_W-1:0]  rt,
    output logic [REG_W-1:0]  shamt,
    output logic [REG_W-1:0]  alu_in,
    output logic [SX_W-1:0]   imm_sx,
    output logic [TGT_W-1:0]  target
);

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    assign alu_in = instr[FUNC_MSB:FUNC_LSB];
    assign imm_sx = sign_ext_imm(instr[IMM_MSB:IMM_LSB]);
    assign target = instr[TGT_MSB:TGT_LSB];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the PC, issues one-cycle requests to a
//   variable-latency instruction memory, registers the returned word and
//   presents it (plus decoded fields) to the decoder with a valid/ready
//   handshake. Redirects from execute have highest priority and squash any
//   in-flight fetch.
//   Ports:
//     clock, reset             clock, asynchronous active-high reset
//     imem_req / imem_addr     fetch request pulse and word address (= pc)
//     imem_valid / imem_rdata  memory response
//     redirect_valid/_pc       load a new fetch address
//     dec_ready                decoder consumes the presented instruction
//     instr_valid, instr,      presented instruction and its address
//     pc_out
//     opcode, rd, rs, rt,      decoded fields (combinational from instr)
//     shamt, alu_in, imm_sx,
//     target
//   Optional (FETCH_PERF_CNT_EN defined):
//     perf_fetched             accepted instructions, wrapping
//     perf_stall               ISSUE cycles stalled by the decoder, wrapping
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int INSN_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              dec_ready,
    output logic              instr_valid,
    output logic [INSN_W-1:0] instr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rs,
    output logic [REG_W-1:0]  rt,
    output logic [REG_W-1:0]  shamt,
    output logic [REG_W-1:0]  alu_in,
    output logic [SX_W-1:0]   imm_sx,
    output logic [TGT_W-1:0]  target
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    fetch_state_e      state_r,  state_nxt_s;
    logic [ADDR_W-1:0] pc_r,     pc_nxt_s;
    logic [INSN_W-1:0] instr_r,  instr_nxt_s;
    logic [ADDR_W-1:0] pc_out_r, pc_out_nxt_s;
    logic              drop_r,   drop_nxt_s;

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            pc_r     <= {ADDR_W{1'b0}};
            instr_r  <= {INSN_W{1'b0}};
            pc_out_r <= {ADDR_W{1'b0}};
            drop_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            instr_r  <= instr_nxt_s;
            pc_out_r <= pc_out_nxt_s;
            drop_r   <= drop_nxt_s;
        end
    end

    // Next-state logic; redirect overrides everything else in every state.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        instr_nxt_s  = instr_r;
        pc_out_nxt_s = pc_out_r;
        drop_nxt_s   = drop_r;
        case (state_r)
            IDLE: begin
                if (redirect_valid) begin
                    pc_nxt_s = redirect_pc;
                end else begin
                    pc_nxt_s = pc_r;
                end
                state_nxt_s = REQ;
            end
            REQ: begin
                // The request has already left, so a redirect here must
                // discard whatever comes back for it.
                if (redirect_valid) begin
                    pc_nxt_s   = redirect_pc;
                    drop_nxt_s = 1'b1;
                end else begin
                    drop_nxt_s = drop_r;
                end
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt_s = redirect_pc;
                    if (imem_valid) begin
                        drop_nxt_s  = 1'b0;
                        state_nxt_s = REQ;
                    end else begin
                        drop_nxt_s  = 1'b1;
                        state_nxt_s = WAIT;
                    end
                end else if (imem_valid) begin
                    if (drop_r) begin
                        drop_nxt_s  = 1'b0;
                        state_nxt_s = REQ;
                    end else begin
                        instr_nxt_s  = imem_rdata;
                        pc_out_nxt_s = pc_r;
                        state_nxt_s  = ISSUE;
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            ISSUE: begin
                if (redirect_valid) begin
                    pc_nxt_s    = redirect_pc;
                    state_nxt_s = REQ;
                end else if (dec_ready) begin
                    pc_nxt_s    = pc_r + ADDR_W'(1);
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                drop_nxt_s  = 1'b0;
            end
        endcase
    end

    assign imem_req    = (state_r == REQ);
    assign imem_addr   = pc_r;
    assign instr_valid = (state_r == ISSUE);
    assign instr       = instr_r;
    assign pc_out      = pc_out_r;

    fetch_field_split #(
        .INSN_W (INSN_W)
    ) u_field_split (
        .instr  (instr_r),
        .opcode (opcode),
        .rd     (rd),
        .rs     (rs),
        .rt     (rt),
        .shamt  (shamt),
        .alu_in (alu_in),
        .imm_sx (imm_sx),
        .target (target)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_r;
    logic        issue_s;

    assign issue_s = (state_r == ISSUE) && !redirect_valid;

    // Handshake and stall counters; a redirect cycle counts as neither.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched_r <= 32'd0;
            perf_stall_r   <= 32'd0;
        end else begin
            if (issue_s && dec_ready) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end else begin
                perf_fetched_r <= perf_fetched_r;
            end
            if (issue_s && !dec_ready) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_stall   = perf_stall_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit with a latency-programmable memory model.
//   Define FETCH_PERF_CNT_EN to also exercise the performance counters.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        dec_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [11:0] pc_out;
    logic [4:0]  opcode, rd, rs, rt, shamt, alu_in;
    logic [31:0] imm_sx;
    logic [26:0] target;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int checks;
    int errors;

    fetch_unit #(.ADDR_W(12), .INSN_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc_out         (pc_out),
        .opcode         (opcode),
        .rd             (rd),
        .rs             (rs),
        .rt             (rt),
        .shamt          (shamt),
        .alu_in         (alu_in),
        .imm_sx         (imm_sx),
        .target         (target)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: one outstanding request, response mem_lat cycles later.
    logic [31:0] mem [0:4095];
    int          mem_lat;
    int          mem_cnt;
    logic [11:0] mem_addr_q;

    initial begin
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
        mem_cnt    = 0;
        mem_addr_q = 12'd0;
    end

    always @(negedge clock) begin
        if (mem_cnt > 0) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem[mem_addr_q];
            end else begin
                imem_valid = 1'b0;
            end
        end else begin
            imem_valid = 1'b0;
        end
        if (imem_req) begin
            mem_cnt    = mem_lat;
            mem_addr_q = imem_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (instr_valid) break;
            @(negedge clock);
        end
        chk({tag, "_valid"}, 64'(instr_valid), 64'd1);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (imem_req) break;
            @(negedge clock);
        end
        chk({tag, "_req"}, 64'(imem_req), 64'd1);
    endtask

    task automatic accept();
        dec_ready = 1'b1;
        @(negedge clock);
        dec_ready = 1'b0;
    endtask

    task automatic redirect(input logic [11:0] target_pc);
        redirect_valid = 1'b1;
        redirect_pc    = target_pc;
        @(negedge clock);
        redirect_valid = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        mem_lat        = 1;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 12'd0;
        dec_ready      = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0000;
        mem[12'h000] = 32'h2842_0005;
        mem[12'h001] = 32'h0001_FFFF;
        mem[12'h002] = 32'h0000_FFFF;
        mem[12'h003] = 32'hAAAA_0003;
        mem[12'h007] = 32'h0800_0000;
        mem[12'h040] = 32'h1234_5678;
        mem[12'h100] = 32'h5555_0100;
        mem[12'h200] = 32'hDEAD_BEEF;
        mem[12'hFFF] = 32'hCAFE_0FFF;

        // Reset state.
        @(negedge clock);
        @(negedge clock);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_req",   64'(imem_req),    64'd0);
        chk("rst_addr",  64'(imem_addr),   64'd0);
        chk("rst_pcout", 64'(pc_out),      64'd0);
        chk("rst_instr", 64'(instr),       64'd0);
        reset = 1'b0;

        // First fetch: req at cycle 1, instr_valid at cycle 3.
        @(negedge clock);
        chk("c1_req",   64'(imem_req),    64'd1);
        chk("c1_addr",  64'(imem_addr),   64'd0);
        chk("c1_valid", 64'(instr_valid), 64'd0);
        @(negedge clock);
        chk("c2_valid", 64'(instr_valid), 64'd0);
        chk("c2_req",   64'(imem_req),    64'd0);
        @(negedge clock);
        chk("c3_valid",  64'(instr_valid), 64'd1);
        chk("c3_instr",  64'(instr),       64'h2842_0005);
        chk("c3_opcode", 64'(opcode),      64'd5);
        chk("c3_rd",     64'(rd),          64'd1);
        chk("c3_rs",     64'(rs),          64'd1);
        chk("c3_imm",    64'(imm_sx),      64'd5);

        // Decoder stall for 4 cycles: outputs hold, no new request.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("stall_valid", 64'(instr_valid), 64'd1);
            chk("stall_instr", 64'(instr),       64'h2842_0005);
            chk("stall_pcout", 64'(pc_out),      64'd0);
            chk("stall_req",   64'(imem_req),    64'd0);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall4", 64'(perf_stall), 64'd4);
`endif
        accept();
        chk("seq_addr1", 64'(imem_addr), 64'd1);

        // Immediate sign extension boundaries.
        wait_valid("imm_neg");
        chk("imm_neg", 64'(imm_sx), 64'hFFFF_FFFF);
        chk("imm_neg_pc", 64'(pc_out), 64'd1);
        accept();
        wait_valid("imm_pos");
        chk("imm_pos", 64'(imm_sx), 64'h0000_FFFF);
        chk("imm_pos_pc", 64'(pc_out), 64'd2);

        // Redirect while waiting on a slow response: stale word dropped.
        mem_lat = 3;
        accept();
        chk("rw_req", 64'(imem_req), 64'd1);
        chk("rw_addr", 64'(imem_addr), 64'd3);
        @(negedge clock);
        redirect(12'h040);
        wait_req("rw_refetch");
        chk("rw_refetch_addr", 64'(imem_addr), 64'h040);
        wait_valid("rw_new");
        chk("rw_instr", 64'(instr),  64'h1234_5678);
        chk("rw_pcout", 64'(pc_out), 64'h040);

        // Redirect coincident with dec_ready at pc=7.
        mem_lat = 1;
        redirect(12'h007);
        chk("r7_addr", 64'(imem_addr), 64'h007);
        wait_valid("r7");
        chk("r7_pcout", 64'(pc_out), 64'h007);
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 12'h100;
        @(negedge clock);
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        chk("rc_req",   64'(imem_req),    64'd1);
        chk("rc_addr",  64'(imem_addr),   64'h100);
        chk("rc_valid", 64'(instr_valid), 64'd0);
        wait_valid("rc");
        chk("rc_pcout", 64'(pc_out), 64'h100);
        chk("rc_instr", 64'(instr),  64'h5555_0100);

        // PC wrap from all-ones.
        redirect(12'hFFF);
        wait_valid("wrap_top");
        chk("wrap_top_pc", 64'(pc_out), 64'hFFF);
        chk("wrap_top_instr", 64'(instr), 64'hCAFE_0FFF);
        accept();
        chk("wrap_req",  64'(imem_req),  64'd1);
        chk("wrap_addr", 64'(imem_addr), 64'h000);
        wait_valid("wrap_zero");
        chk("wrap_zero_pc", 64'(pc_out), 64'h000);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", 64'(perf_fetched), 64'd4);
`endif

        // Reset while waiting: back to reset values, late response ignored.
        mem_lat = 3;
        redirect(12'h200);
        chk("rs_addr", 64'(imem_addr), 64'h200);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rs_valid", 64'(instr_valid), 64'd0);
        chk("rs_req",   64'(imem_req),    64'd0);
        chk("rs_pcout", 64'(pc_out),      64'd0);
        chk("rs_instr", 64'(instr),       64'd0);
        chk("rs_pc",    64'(imem_addr),   64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rs_perf_f", 64'(perf_fetched), 64'd0);
        chk("rs_perf_s", 64'(perf_stall),   64'd0);
`endif
        @(negedge clock);
        reset = 1'b0;
        wait_req("rs_refetch");
        chk("rs_refetch_addr", 64'(imem_addr), 64'd0);
        wait_valid("rs_new");
        chk("rs_new_instr", 64'(instr),  64'h2842_0005);
        chk("rs_new_pcout", 64'(pc_out), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
